avg_pool_collector: RTL and testbench

//  Read-side end of the multi-channel average-pool array. Waits for every channel's

---
 rtl/avg_pool_collector.sv | 143 ++++++++++++++
 tb/tb_avg_pool_collector.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_pool_collector.sv
// Captures each channel's pooled word on its finished rising edge, then streams one channel per beat over valid/ready, holding the beat while stalled.
// out_valid rises 2 cycles after the last finish edge; define AVG_COLLECT_SUM_EN to also capture and stream sum_in as out_sum.
module avg_pool_collector #(
  parameter int DATAWIDTH     = 32,
  parameter int CHANNEL_COUNT = 1,
  localparam int CH_W = ($clog2(CHANNEL_COUNT) > 0) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] avg_in [CHANNEL_COUNT],
`ifdef AVG_COLLECT_SUM_EN
  input  logic [DATAWIDTH-1:0] sum_in [CHANNEL_COUNT],
`endif
  input  logic                 finished_in [CHANNEL_COUNT],
  output logic [DATAWIDTH-1:0] out_data,
`ifdef AVG_COLLECT_SUM_EN
  output logic [DATAWIDTH-1:0] out_sum,
`endif
  output logic [CH_W-1:0]      out_channel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic [1:0] {COLLECT, STREAM, REARM} state_t;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNEL_COUNT - 1);

  state_t                   state, state_nxt;
  logic [CHANNEL_COUNT-1:0] fin_now, fin_q, rise, cap_flag, cap_nxt, cap_en;
  logic [DATAWIDTH-1:0]     avg_q [CHANNEL_COUNT];
  logic [DATAWIDTH-1:0]     avg_sel;
  logic [CH_W-1:0]          ch_nxt;
  logic                     valid_nxt, last_nxt, overrun_nxt;
`ifdef AVG_COLLECT_SUM_EN
  logic [DATAWIDTH-1:0]     sum_q [CHANNEL_COUNT];
  logic [DATAWIDTH-1:0]     sum_sel;
`endif

  always_comb begin
    fin_now = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++) fin_now[i] = finished_in[i];
    rise = fin_now & ~fin_q;
  end

  always_comb begin
    state_nxt   = state;
    cap_nxt     = cap_flag;
    cap_en      = '0;
    ch_nxt      = out_channel;
    valid_nxt   = out_valid;
    last_nxt    = out_last;
    overrun_nxt = overrun;
    case (state)
      COLLECT: begin
        // A second edge on an already captured channel keeps the first word.
        cap_en  = rise & ~cap_flag;
        cap_nxt = cap_flag | rise;
        if (|(rise & cap_flag)) overrun_nxt = 1'b1;
        if (&cap_flag) begin
          state_nxt = STREAM;
          valid_nxt = 1'b1;
          ch_nxt    = '0;
          last_nxt  = (LAST_CH == '0);
        end
      end
      STREAM: begin
        if (|rise) overrun_nxt = 1'b1;
        if (out_valid && out_ready) begin
          if (out_last) begin
            state_nxt = REARM;
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            cap_nxt   = '0;
          end else begin
            ch_nxt   = out_channel + CH_W'(1);
            last_nxt = (ch_nxt == LAST_CH);
          end
        end
      end
      REARM: begin
        if (!(|fin_now)) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    avg_sel = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++)
      if (ch_nxt == CH_W'(i)) avg_sel = avg_q[i];
  end

`ifdef AVG_COLLECT_SUM_EN
  always_comb begin
    sum_sel = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++)
      if (ch_nxt == CH_W'(i)) sum_sel = sum_q[i];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      fin_q       <= '0;
      cap_flag    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_channel <= '0;
      out_data    <= '0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < CHANNEL_COUNT; i++) avg_q[i] <= '0;
    end else begin
      state       <= state_nxt;
      fin_q       <= fin_now;
      cap_flag    <= cap_nxt;
      out_valid   <= valid_nxt;
      out_last    <= last_nxt;
      out_channel <= ch_nxt;
      overrun     <= overrun_nxt;
      busy        <= (state_nxt != COLLECT) || (|cap_nxt);
      if (valid_nxt) out_data <= avg_sel;
      for (int i = 0; i < CHANNEL_COUNT; i++)
        if (cap_en[i]) avg_q[i] <= avg_in[i];
    end
  end

`ifdef AVG_COLLECT_SUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum <= '0;
      for (int i = 0; i < CHANNEL_COUNT; i++) sum_q[i] <= '0;
    end else begin
      if (valid_nxt) out_sum <= sum_sel;
      for (int i = 0; i < CHANNEL_COUNT; i++)
        if (cap_en[i]) sum_q[i] <= sum_in[i];
    end
  end
`endif

endmodule

// File: tb/tb_avg_pool_collector.sv
// Scoreboarded bench for avg_pool_collector: a 4-channel instance checked by a beat monitor, plus a 1-channel instance.
module tb_avg_pool_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy4, rdy1;
  logic [31:0] avg4 [4];
  logic        fin4 [4];
  logic [31:0] data4;
  logic [1:0]  ch4;
  logic        valid4, last4, busy4, ovr4;
  logic [31:0] avg1 [1];
  logic        fin1 [1];
  logic [31:0] data1;
  logic [0:0]  ch1;
  logic        valid1, last1, busy1, ovr1;
`ifdef AVG_COLLECT_SUM_EN
  logic [31:0] sum4 [4];
  logic [31:0] sum1 [1];
  logic [31:0] osum4, osum1;
`endif

  avg_pool_collector #(.DATAWIDTH(32), .CHANNEL_COUNT(4)) dut4 (
    .clk(clk), .rst(rst), .avg_in(avg4),
`ifdef AVG_COLLECT_SUM_EN
    .sum_in(sum4), .out_sum(osum4),
`endif
    .finished_in(fin4), .out_data(data4), .out_channel(ch4), .out_valid(valid4),
    .out_ready(rdy4), .out_last(last4), .busy(busy4), .overrun(ovr4)
  );

  avg_pool_collector #(.DATAWIDTH(32), .CHANNEL_COUNT(1)) dut1 (
    .clk(clk), .rst(rst), .avg_in(avg1),
`ifdef AVG_COLLECT_SUM_EN
    .sum_in(sum1), .out_sum(osum1),
`endif
    .finished_in(fin1), .out_data(data1), .out_channel(ch1), .out_valid(valid1),
    .out_ready(rdy1), .out_last(last1), .busy(busy1), .overrun(ovr1)
  );

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] dat;
    logic [31:0] sum;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input int c, input logic [31:0] d, input logic [31:0] s);
    beat_t b;
    b.ch   = 2'(c);
    b.dat  = d;
    b.sum  = s;
    b.last = (c == 3);
    exp_q.push_back(b);
  endtask

  task automatic set_words(input logic [31:0] abase, input logic [31:0] sbase);
    for (int i = 0; i < 4; i++) begin
      avg4[i] = abase + 32'(i);
`ifdef AVG_COLLECT_SUM_EN
      sum4[i] = sbase + 32'(i);
`else
      if (sbase == 32'h0) avg4[i] = abase + 32'(i);
`endif
    end
  endtask

  task automatic push_all(input logic [31:0] abase, input logic [31:0] sbase);
    for (int i = 0; i < 4; i++) push_beat(i, abase + 32'(i), sbase + 32'(i));
  endtask

  task automatic set_fin(input logic v);
    for (int i = 0; i < 4; i++) fin4[i] = v;
  endtask

  task automatic drain(input string name, input int maxc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops one expected beat per transfer, and checks stalled beats stay put.
  initial begin
    beat_t       e;
    logic        stalled;
    logic [1:0]  hold_ch;
    logic [31:0] hold_dat;
    stalled  = 1'b0;
    hold_ch  = '0;
    hold_dat = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", 64'(valid4), 64'd1);
          chk("stall_chan", 64'(ch4), 64'(hold_ch));
          chk("stall_data", 64'(data4), 64'(hold_dat));
        end
        stalled = 1'b0;
        if (valid4 && rdy4) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat: got channel %0d data 0x%0h, want no beat", ch4, data4);
          end else begin
            e = exp_q.pop_front();
            chk("beat_chan", 64'(ch4), 64'(e.ch));
            chk("beat_data", 64'(data4), 64'(e.dat));
            chk("beat_last", 64'(last4), 64'(e.last));
`ifdef AVG_COLLECT_SUM_EN
            chk("beat_sum", 64'(osum4), 64'(e.sum));
`endif
          end
        end else if (valid4) begin
          stalled  = 1'b1;
          hold_ch  = ch4;
          hold_dat = data4;
        end
      end
    end
  end

  initial begin
    int n;
    rst     = 1'b1;
    rdy4    = 1'b0;
    rdy1    = 1'b0;
    avg1[0] = '0;
    fin1[0] = 1'b0;
`ifdef AVG_COLLECT_SUM_EN
    sum1[0] = '0;
`endif
    set_words(32'h0, 32'h0);
    set_fin(1'b0);
    repeat (3) tick();

    chk("rst_valid", 64'(valid4), 64'd0);
    chk("rst_last", 64'(last4), 64'd0);
    chk("rst_chan", 64'(ch4), 64'd0);
    chk("rst_data", 64'(data4), 64'd0);
    chk("rst_overrun", 64'(ovr4), 64'd0);
    chk("rst_busy", 64'(busy4), 64'd0);
    chk("rst_valid1", 64'(valid1), 64'd0);
`ifdef AVG_COLLECT_SUM_EN
    chk("rst_sum", 64'(osum4), 64'd0);
`endif
    rst = 1'b0;

    // Staggered finish order 3,1,0,2, two cycles apart.
    set_words(32'h3F800000, 32'h42C80000);
    push_all(32'h3F800000, 32'h42C80000);
    rdy4 = 1'b1;
    fin4[3] = 1'b1;
    tick();
    chk("busy_first_cap", 64'(busy4), 64'd1);
    tick();
    fin4[1] = 1'b1;
    tick(); tick();
    fin4[0] = 1'b1;
    tick(); tick();
    fin4[2] = 1'b1;
    tick();
    chk("latency_not_yet", 64'(valid4), 64'd0);
    tick();
    chk("latency_valid", 64'(valid4), 64'd1);
    chk("first_chan", 64'(ch4), 64'd0);
    tick(); tick(); tick();
    chk("b2b_chan3", 64'(ch4), 64'd3);
    chk("b2b_last", 64'(last4), 64'd1);
    tick();
    chk("after_last_valid", 64'(valid4), 64'd0);
    chk("rearm_busy", 64'(busy4), 64'd1);
    chk("stream1_drained", 64'(exp_q.size()), 64'd0);
    chk("no_overrun_yet", 64'(ovr4), 64'd0);

    // Finished held high: no second stream until all drop.
    repeat (6) tick();
    chk("held_no_stream", 64'(valid4), 64'd0);
    chk("held_busy", 64'(busy4), 64'd1);
    set_fin(1'b0);
    tick();
    chk("rearmed_idle", 64'(busy4), 64'd0);

    // All finish together with new words; ready toggles 1,0,0,1.
    set_words(32'h40000000, 32'h44000000);
    push_all(32'h40000000, 32'h44000000);
    set_fin(1'b1);
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      rdy4 = ((c % 4) == 0) || ((c % 4) == 3);
      tick();
    end
    chk("stall_stream_drained", 64'(exp_q.size()), 64'd0);
    rdy4 = 1'b1;
    repeat (4) tick();
    chk("stall_stream_done", 64'(valid4), 64'd0);
    set_fin(1'b0);
    tick();

    // Ch2 pulses twice before ch0 finishes: first word kept, overrun sticky.
    set_words(32'h40400000, 32'h44400000);
    push_all(32'h40400000, 32'h44400000);
    fin4[1] = 1'b1;
    fin4[3] = 1'b1;
    fin4[2] = 1'b1;
    tick();
    fin4[2] = 1'b0;
    tick();
    chk("overrun_before", 64'(ovr4), 64'd0);
    avg4[2] = 32'h4040BEEF;
`ifdef AVG_COLLECT_SUM_EN
    sum4[2] = 32'h4440BEEF;
`endif
    fin4[2] = 1'b1;
    tick();
    chk("overrun_set", 64'(ovr4), 64'd1);
    fin4[0] = 1'b1;
    drain("overrun_stream_drained", 20);
    chk("overrun_sticky", 64'(ovr4), 64'd1);
    repeat (2) tick();
    set_fin(1'b0);
    tick();

    // Reset during beat 2, finished held high: full restart from ch0.
    set_words(32'h40800000, 32'h44800000);
    push_all(32'h40800000, 32'h44800000);
    set_fin(1'b1);
    n = 0;
    while (!(valid4 && ch4 == 2'd2) && n < 20) begin
      tick();
      n++;
    end
    chk("reach_beat2", 64'(valid4 && ch4 == 2'd2), 64'd1);
    rst  = 1'b1;
    rdy4 = 1'b0;
    exp_q.delete();
    push_all(32'h40800000, 32'h44800000);
    tick();
    chk("midrst_valid", 64'(valid4), 64'd0);
    chk("midrst_overrun", 64'(ovr4), 64'd0);
    chk("midrst_busy", 64'(busy4), 64'd0);
    chk("midrst_chan", 64'(ch4), 64'd0);
    rst  = 1'b0;
    rdy4 = 1'b1;
    tick();
    chk("recap_not_yet", 64'(valid4), 64'd0);
    tick();
    chk("recap_valid", 64'(valid4), 64'd1);
    drain("restart_stream_drained", 20);
    set_fin(1'b0);

    // Single-channel instance.
    avg1[0] = 32'h3F000000;
`ifdef AVG_COLLECT_SUM_EN
    sum1[0] = 32'h43290000;
`endif
    rdy1    = 1'b1;
    fin1[0] = 1'b1;
    tick();
    chk("one_not_yet", 64'(valid1), 64'd0);
    tick();
    chk("one_valid", 64'(valid1), 64'd1);
    chk("one_last", 64'(last1), 64'd1);
    chk("one_chan", 64'(ch1), 64'd0);
    chk("one_data", 64'(data1), 64'h3F000000);
`ifdef AVG_COLLECT_SUM_EN
    chk("one_sum", 64'(osum1), 64'h43290000);
`endif
    tick();
    chk("one_done", 64'(valid1), 64'd0);
    chk("one_overrun", 64'(ovr1), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
